// File: rtl/udp_rx_parser.sv
// udp_rx_parser
//   Parses an IPv4 packet byte stream (Ethernet header already removed),
//   accepts UDP datagrams addressed to ip_addr:port, and forwards the payload.
//
//   Ports
//     RX_CLK        clock, rising edge
//     RST_N         asynchronous active-low reset
//     ip_data_v     byte valid; low between frames (falling edge = end of frame)
//     ip_data       IPv4 packet byte, first header byte first
//     ip_addr       own IPv4 address, big-endian
//     port          own UDP port, big-endian
//     rx_udp_data_v payload byte strobe (one cycle after the input byte)
//     rx_udp_data   payload byte
//     src_ip        source IP of last accepted datagram
//     src_port      source port of last accepted datagram
//     rx_udp_len    payload length of last accepted datagram
//     rx_udp_done   pulse: payload fully delivered
//     rx_udp_err    pulse: accepted datagram truncated or malformed
module udp_rx_parser #(
    parameter int OCT = 8
) (
    input  logic             RX_CLK,
    input  logic             RST_N,
    input  logic             ip_data_v,
    input  logic [OCT-1:0]   ip_data,
    input  logic [OCT*4-1:0] ip_addr,
    input  logic [OCT*2-1:0] port,
    output logic             rx_udp_data_v,
    output logic [OCT-1:0]   rx_udp_data,
    output logic [OCT*4-1:0] src_ip,
    output logic [OCT*2-1:0] src_port,
    output logic [OCT*2-1:0] rx_udp_len,
    output logic             rx_udp_done,
    output logic             rx_udp_err
);

    localparam int LW = OCT * 2;
    localparam logic [LW-1:0] UDP_HDR_BYTES = LW'(8);

    typedef enum logic [2:0] {IDLE, IP_HDR, UDP_HDR, PAYLOAD, DROP} state_t;

    state_t             state;
    logic [15:0]        cnt;
    logic               armed;     // set once ip_data_v has been seen low
    logic [3:0]         ihl;
    logic               addr_bad;
    logic [OCT*4-1:0]   sh_ip;
    logic [LW-1:0]      sh_port;
    logic [LW-1:0]      sh_len;

    logic [15:0]        idx;       // IP header byte index (byte 0 is consumed in IDLE)
    logic [15:0]        hdr_last;
    logic [OCT-1:0]     addr_byte;
    logic [OCT-1:0]     port_byte;
    logic               addr_mis;
    logic               proto_bad;

    always_comb begin
        idx      = cnt + 16'd1;
        hdr_last = {10'd0, ihl - 4'd1, 2'b11};
        case (idx[1:0])
            2'd0:    addr_byte = ip_addr[OCT*4-1 -: OCT];
            2'd1:    addr_byte = ip_addr[OCT*3-1 -: OCT];
            2'd2:    addr_byte = ip_addr[OCT*2-1 -: OCT];
            default: addr_byte = ip_addr[OCT-1:0];
        endcase
        port_byte = cnt[0] ? port[OCT-1:0] : port[LW-1 -: OCT];
        addr_mis  = (idx >= 16'd16) && (idx <= 16'd19) && (ip_data != addr_byte);
        proto_bad = (ip_data != OCT'(17));
    end

    always_ff @(posedge RX_CLK or negedge RST_N) begin
        if (!RST_N) begin
            state         <= IDLE;
            cnt           <= '0;
            armed         <= 1'b0;
            ihl           <= '0;
            addr_bad      <= 1'b0;
            sh_ip         <= '0;
            sh_port       <= '0;
            sh_len        <= '0;
            rx_udp_data_v <= 1'b0;
            rx_udp_data   <= '0;
            src_ip        <= '0;
            src_port      <= '0;
            rx_udp_len    <= '0;
            rx_udp_done   <= 1'b0;
            rx_udp_err    <= 1'b0;
        end else begin
            rx_udp_data_v <= 1'b0;
            rx_udp_done   <= 1'b0;
            rx_udp_err    <= 1'b0;
            if (!ip_data_v)
                armed <= 1'b1;

            case (state)
                IDLE: begin
                    // armed blocks the tail of a frame that was cut by reset
                    if (ip_data_v && armed) begin
                        cnt      <= '0;
                        ihl      <= ip_data[3:0];
                        addr_bad <= 1'b0;
                        if (ip_data[OCT-1 -: 4] != 4'd4 || ip_data[3:0] < 4'd5)
                            state <= DROP;
                        else
                            state <= IP_HDR;
                    end
                end

                IP_HDR: begin
                    if (!ip_data_v) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 16'd1;
                        if (idx >= 16'd12 && idx <= 16'd15)
                            sh_ip <= {sh_ip[OCT*3-1:0], ip_data};
                        if (addr_mis)
                            addr_bad <= 1'b1;
                        // address verdict is taken at byte 19 even if options follow
                        if ((idx == 16'd9 && proto_bad) ||
                            (idx == 16'd19 && (addr_bad || addr_mis))) begin
                            state <= DROP;
                            cnt   <= '0;
                        end else if (idx == hdr_last) begin
                            state <= UDP_HDR;
                            cnt   <= '0;
                        end
                    end
                end

                UDP_HDR: begin
                    if (!ip_data_v) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 16'd1;
                        case (cnt)
                            16'd0, 16'd1: sh_port <= {sh_port[OCT-1:0], ip_data};
                            16'd2, 16'd3: begin
                                if (ip_data != port_byte) begin
                                    state <= DROP;
                                    cnt   <= '0;
                                end
                            end
                            16'd4, 16'd5: sh_len <= {sh_len[OCT-1:0], ip_data};
                            16'd7: begin
                                cnt <= '0;
                                if (sh_len < UDP_HDR_BYTES) begin
                                    rx_udp_err <= 1'b1;
                                    state      <= DROP;
                                end else begin
                                    src_ip     <= sh_ip;
                                    src_port   <= sh_port;
                                    rx_udp_len <= sh_len - UDP_HDR_BYTES;
                                    if (sh_len == UDP_HDR_BYTES) begin
                                        rx_udp_done <= 1'b1;
                                        state       <= DROP;
                                    end else begin
                                        state <= PAYLOAD;
                                    end
                                end
                            end
                            default: ;
                        endcase
                    end
                end

                PAYLOAD: begin
                    if (!ip_data_v) begin
                        rx_udp_err <= 1'b1;
                        state      <= IDLE;
                        cnt        <= '0;
                    end else begin
                        rx_udp_data_v <= 1'b1;
                        rx_udp_data   <= ip_data;
                        cnt           <= cnt + 16'd1;
                        if ((cnt + 16'd1) == 16'(rx_udp_len)) begin
                            rx_udp_done <= 1'b1;
                            state       <= DROP;
                            cnt         <= '0;
                        end
                    end
                end

                DROP: begin
                    if (!ip_data_v) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                end

                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule
